// File: rtl/gate_tree_pkg.sv
// Shared definitions for the pipelined mux-built reduction tree: the
// reduction mode encoding and the helpers that size and lay out the tree.
package gate_tree_pkg;

    typedef enum logic [1:0] {
        MODE_OR  = 2'd0,
        MODE_AND = 2'd1,
        MODE_XOR = 2'd2,
        MODE_NOR = 2'd3
    } mode_e;

    // Depth of a binary tree over n leaves, which is also the pipeline latency.
    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

    // Tree nodes are stored flat, level by level: level 1 first, then level 2,
    // and so on. This returns the index of the first node of level lvl.
    function automatic int level_offset(input int n, input int lvl);
        return n - (n >> (lvl - 1));
    endfunction

endpackage

// File: rtl/gate_cell_mux.sv
// One-bit configurable gate built only from 2:1 mux cells. It provides
// OR, AND and XOR; NOR is treated as OR here because the inversion for NOR
// happens once at the last tree stage.
module gate_cell_mux
    import gate_tree_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] mode,
    output logic       y
);

    logic not_b;
    logic or_y;
    logic and_y;
    logic xor_y;
    logic sel_lo;
    logic sel_hi;

    // Inverted b, needed by the XOR cell, realised as a mux with constant inputs.
    mux2_cell u_inv_b (.sel(b), .d0(1'b1), .d1(1'b0), .y(not_b));

    // OR = a ? 1 : b
    mux2_cell u_or    (.sel(a), .d0(b),    .d1(1'b1),  .y(or_y));

    // AND = a ? b : 0
    mux2_cell u_and   (.sel(a), .d0(1'b0), .d1(b),     .y(and_y));

    // XOR = a ? ~b : b
    mux2_cell u_xor   (.sel(a), .d0(b),    .d1(not_b), .y(xor_y));

    // Mode selection: bit 0 picks within each pair, bit 1 picks the pair.
    // Pair 0 covers OR/AND; pair 1 covers XOR and NOR, where NOR uses OR.
    mux2_cell u_sel_lo (.sel(mode[0]), .d0(or_y),   .d1(and_y),  .y(sel_lo));
    mux2_cell u_sel_hi (.sel(mode[0]), .d0(xor_y),  .d1(or_y),   .y(sel_hi));
    mux2_cell u_sel    (.sel(mode[1]), .d0(sel_lo), .d1(sel_hi), .y(y));

endmodule

// File: rtl/mux2_cell.sv
// Basic 2:1 multiplexer cell; every gate in the reduction tree is built
// from instances of this cell.
module mux2_cell (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/gate_tree_pipe.sv
// Streaming bitwise reduction of N_IN words to one word through a binary
// tree of mux-built gates, with one register stage per tree level and a
// single global advance signal driven by the output handshake.
module gate_tree_pipe
    import gate_tree_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             out_mode
);

    localparam int LEVELS = tree_levels(N_IN);
    localparam int NODES  = N_IN - 1;
    localparam int LAST   = N_IN - 2;

    // Per-level pipeline state; node_q holds every tree node, level by level.
    logic             valid_q [1:LEVELS];
    logic [1:0]       mode_q  [1:LEVELS];
    logic [WIDTH-1:0] node_q  [NODES];

    // Values presented to each level's registers on the next advance.
    logic             valid_in [1:LEVELS];
    logic [1:0]       mode_in  [1:LEVELS];
    logic [WIDTH-1:0] node_d   [NODES];

    logic adv;

    // The whole pipe moves together whenever the final stage is empty or
    // being consumed, so bubbles in front of it are carried along.
    assign adv       = !valid_q[LEVELS] || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[LEVELS];
    assign out_mode  = mode_q[LEVELS];
    assign out_data  = node_q[LAST];

    generate
        for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
            localparam int OFF = level_offset(N_IN, l);
            localparam int CNT = N_IN >> l;

            if (l == 1) begin : g_src_in
                assign valid_in[l] = in_valid;
                assign mode_in[l]  = in_mode;
            end else begin : g_src_reg
                assign valid_in[l] = valid_q[l-1];
                assign mode_in[l]  = mode_q[l-1];
            end

            for (genvar k = 0; k < CNT; k++) begin : g_node
                logic [WIDTH-1:0] a_w;
                logic [WIDTH-1:0] b_w;
                logic [WIDTH-1:0] tree_y;

                if (l == 1) begin : g_leaf
                    assign a_w = in_data[(2*k)*WIDTH   +: WIDTH];
                    assign b_w = in_data[(2*k+1)*WIDTH +: WIDTH];
                end else begin : g_inner
                    localparam int PREV = level_offset(N_IN, l - 1);
                    assign a_w = node_q[PREV + 2*k];
                    assign b_w = node_q[PREV + 2*k + 1];
                end

                for (genvar j = 0; j < WIDTH; j++) begin : g_bit
                    gate_cell_mux u_cell (
                        .a    (a_w[j]),
                        .b    (b_w[j]),
                        .mode (mode_in[l]),
                        .y    (tree_y[j])
                    );
                end

                if (l == LEVELS) begin : g_final
                    // The root applies the NOR inversion just before the
                    // output register, so the output stays register-driven.
                    logic             is_nor;
                    logic [WIDTH-1:0] inv_y;
                    logic [WIDTH-1:0] final_y;

                    assign is_nor = (mode_in[l] == MODE_NOR);

                    for (genvar j = 0; j < WIDTH; j++) begin : g_inv
                        mux2_cell u_inv (
                            .sel (tree_y[j]),
                            .d0  (1'b1),
                            .d1  (1'b0),
                            .y   (inv_y[j])
                        );
                        mux2_cell u_pick (
                            .sel (is_nor),
                            .d0  (tree_y[j]),
                            .d1  (inv_y[j]),
                            .y   (final_y[j])
                        );
                    end

                    assign node_d[OFF + k] = final_y;
                end else begin : g_pass
                    assign node_d[OFF + k] = tree_y;
                end
            end
        end
    endgenerate

    // Pipeline registers: clear everything on reset, otherwise shift one level
    // per advance. Data and mode load only alongside a valid word, so after
    // reset the output word stays 0 until the first real result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 1; l <= LEVELS; l++) begin
                valid_q[l] <= 1'b0;
                mode_q[l]  <= 2'd0;
            end
            for (int i = 0; i < NODES; i++) begin
                node_q[i] <= '0;
            end
        end else if (adv) begin
            for (int l = 1; l <= LEVELS; l++) begin
                valid_q[l] <= valid_in[l];
                if (valid_in[l]) begin
                    mode_q[l] <= mode_in[l];
                    for (int k = 0; k < (N_IN >> l); k++) begin
                        node_q[level_offset(N_IN, l) + k] <= node_d[level_offset(N_IN, l) + k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_tree_pipe.sv
// Scoreboard bench for gate_tree_pipe at N_IN=4, WIDTH=8.
module tb_gate_tree_pipe;
    import gate_tree_pkg::*;

    localparam int N_IN  = 4;
    localparam int WIDTH = 8;
    localparam int HIST  = 4096;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [1:0]            in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_mode;

    typedef struct packed {
        logic [1:0]       mode;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic             hist_valid [0:HIST-1];
    logic [WIDTH-1:0] hist_data  [0:HIST-1];

    logic             stall_seen = 1'b0;
    logic [WIDTH-1:0] stall_data;
    logic [1:0]       stall_mode;
    logic             rand_done  = 1'b0;

    gate_tree_pipe #(.N_IN(N_IN), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural reference, written with plain operators.
    function automatic logic [WIDTH-1:0] ref_reduce(input logic [31:0] d, input logic [1:0] m);
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] w;
        acc = d[7:0];
        for (int i = 1; i < N_IN; i++) begin
            w = d[i*WIDTH +: WIDTH];
            case (m)
                2'd1:    acc = acc & w;
                2'd2:    acc = acc ^ w;
                default: acc = acc | w;
            endcase
        end
        if (m == 2'd3) acc = ~acc;
        return acc;
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] w0, input logic [7:0] w1,
                                          input logic [7:0] w2, input logic [7:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Presents one word, waits for acceptance, and records the expected result.
    task automatic applyStimulus(input logic [31:0] data, input logic [1:0] mode,
                                 input logic [7:0] expected, output int xfer_cyc);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_ready_timeout actual=0 required=1");
            xfer_cyc = -1;
        end else begin
            xfer_cyc = cyc;
            if (!rst) begin
                e.mode = mode;
                e.data = expected;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic hist_check(input string name, input int c, input logic exp_valid,
                              input logic [7:0] exp_data, input logic check_data);
        if (c < 0 || c >= HIST) begin
            checkOutput({name, "_range"}, c, 0);
        end else begin
            checkOutput({name, "_valid"}, hist_valid[c], exp_valid);
            if (check_data) checkOutput({name, "_data"}, hist_data[c], exp_data);
        end
    endtask

    // Monitor: logs the output each cycle, pops the scoreboard on every output
    // transfer, and checks that a stalled output holds its value.
    always @(negedge clk) begin
        if (cyc < HIST) begin
            hist_valid[cyc] = out_valid;
            hist_data[cyc]  = out_data;
        end
        if (!rst) begin
            if (stall_seen && out_valid) begin
                checkOutput("hold_data", out_data, stall_data);
                checkOutput("hold_mode", out_mode, stall_mode);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output actual=%h required=none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("sb_data", out_data, mon_e.data);
                    checkOutput("sb_mode", out_mode, mon_e.mode);
                end
            end
            stall_seen = out_valid && !out_ready;
            stall_data = out_data;
            stall_mode = out_mode;
        end else begin
            stall_seen = 1'b0;
        end
    end

    initial begin
        int c, c1, c2, c3;
        logic [31:0] d;
        logic [1:0]  m;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_mode", out_mode, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // OR with latency check
        applyStimulus(pack4(8'h01, 8'h02, 8'h04, 8'h80), MODE_OR, 8'h87, c);
        repeat (2) @(negedge clk);
        #1;
        hist_check("or_early", c + 1, 1'b0, 8'h00, 1'b0);
        hist_check("or_result", c + 2, 1'b1, 8'h87, 1'b1);
        @(posedge clk); #1;

        // AND, XOR, NOR back to back
        applyStimulus(pack4(8'hFF, 8'hF0, 8'h3C, 8'hFF), MODE_AND, 8'h30, c1);
        applyStimulus(pack4(8'h0F, 8'hF0, 8'hAA, 8'h00), MODE_XOR, 8'h55, c2);
        applyStimulus(pack4(8'h00, 8'h00, 8'h00, 8'h01), MODE_NOR, 8'hFE, c3);
        checkOutput("b2b_accept", c3 - c1, 2);
        repeat (2) @(negedge clk);
        #1;
        hist_check("b2b_and", c1 + 2, 1'b1, 8'h30, 1'b1);
        hist_check("b2b_xor", c1 + 3, 1'b1, 8'h55, 1'b1);
        hist_check("b2b_nor", c1 + 4, 1'b1, 8'hFE, 1'b1);
        @(posedge clk); #1;
        drain();

        // Backpressure: consumer stalls for 5 cycles while words keep coming
        fork
            begin
                int cb;
                for (int i = 0; i < 6; i++) begin
                    logic [7:0] b;
                    b = 8'(i + 1);
                    applyStimulus(pack4(b, b, b, b), MODE_OR, b, cb);
                end
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    checkOutput("bp_in_ready", in_ready, 0);
                    checkOutput("bp_out_valid", out_valid, 1);
                    checkOutput("bp_out_data", out_data, 8'h01);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Bubble: valid pattern 1,0,1
        applyStimulus(pack4(8'hF0, 8'hF0, 8'hF0, 8'hF0), MODE_AND, 8'hF0, c1);
        @(posedge clk); #1;
        applyStimulus(pack4(8'h00, 8'h00, 8'h00, 8'h0F), MODE_OR, 8'h0F, c2);
        checkOutput("bubble_gap", c2 - c1, 2);
        repeat (2) @(negedge clk);
        #1;
        hist_check("bubble_first", c1 + 2, 1'b1, 8'hF0, 1'b1);
        hist_check("bubble_hole", c1 + 3, 1'b0, 8'h00, 1'b0);
        hist_check("bubble_second", c1 + 4, 1'b1, 8'h0F, 1'b1);
        @(posedge clk); #1;
        drain();

        // Reset mid-flight: two words in the pipe, then a one-cycle reset
        out_ready = 1'b0;
        applyStimulus(pack4(8'h11, 8'h22, 8'h44, 8'h88), MODE_XOR, 8'hFF, c1);
        applyStimulus(pack4(8'h01, 8'h00, 8'h00, 8'h00), MODE_XOR, 8'h01, c2);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        in_mode   = MODE_OR;
        @(negedge clk);
        checkOutput("rst_cycle_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_data", out_data, 0);
        checkOutput("midrst_out_mode", out_mode, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_output", out_valid, 0);
        end
        @(posedge clk); #1;

        // Random traffic with random consumer stalls
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    d = $urandom;
                    m = 2'($urandom_range(0, 3));
                    applyStimulus(d, m, ref_reduce(d, m), c);
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        checkOutput("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
